light_timer: RTL and testbench

LIGHT_TIMER -- requirements
Module: light_timer

---
 rtl/light_timer_pkg.sv | 19 +
 rtl/light_timer_tick_gen.sv | 38 +++
 rtl/light_timer.sv | 77 +++++++
 tb/tb_light_timer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/light_timer_pkg.sv
// Shared constants for the traffic-light timer and the light-controller FSMs:
// mode encodings and default phase/prescaler settings.
package light_timer_pkg;

    localparam logic MODE_LONG  = 1'b0;
    localparam logic MODE_SHORT = 1'b1;

    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_LONG_T  = 5;
    localparam int unsigned DEF_SHORT_T = 2;
    localparam int unsigned DEF_CNT_W   = 8;

    // Ticks in a phase for the given mode.
    function automatic int unsigned phase_ticks(input logic m, input int unsigned long_t,
                                                input int unsigned short_t);
        return (m == MODE_SHORT) ? short_t : long_t;
    endfunction

endpackage

// File: rtl/light_timer_tick_gen.sv
// Prescaler for light_timer: counts 0..CLK_DIV-1 and flags the last count as a tick.
// clr restarts the count from zero so a new phase begins on a clean tick boundary.
module tick_gen
    import light_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = pre_q;
        if (clr || tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/light_timer.sv
// Phase timer for the traffic-light controller: emits a one-cycle timeout pulse every
// N*CLK_DIV cycles. Optional countdown output under macro LIGHT_TIMER_REMAIN_EN.
module light_timer
    import light_timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned LONG_T  = DEF_LONG_T,
    parameter int unsigned SHORT_T = DEF_SHORT_T,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    output logic             timeout
`ifdef LIGHT_TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0] remain
`endif
);

    localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(phase_ticks(MODE_LONG, LONG_T, SHORT_T) - 1);
    localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(phase_ticks(MODE_SHORT, LONG_T, SHORT_T) - 1);

    logic             mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             mode_chg;
    logic             tick;
    logic [CNT_W-1:0] load_val;

    assign mode_chg = (mode != mode_q);
    // On a change mode is the new mode; otherwise mode equals mode_q, so one mux serves both.
    assign load_val = (mode == MODE_SHORT) ? LOAD_SHORT : LOAD_LONG;

    tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (mode_chg),
        .tick (tick)
    );

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (mode_chg) begin
            cnt_d = load_val;
        end else if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                cnt_d     = load_val;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_LONG;
            cnt_q     <= LOAD_LONG;
            timeout_q <= 1'b0;
        end else begin
            mode_q    <= mode;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

`ifdef LIGHT_TIMER_REMAIN_EN
    assign remain = cnt_q + 1'b1;
`endif

endmodule

// File: tb/tb_light_timer.sv
// Scoreboard bench for light_timer: stimulus pushes expected timeout edges,
// a negedge monitor pops and compares on every pulse.
module tb_light_timer;
    import light_timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode = 1'b0;
    logic timeout;
`ifdef LIGHT_TIMER_REMAIN_EN
    logic [7:0] remain;
`endif

    light_timer #(
        .CLK_DIV(4),
        .LONG_T (5),
        .SHORT_T(2),
        .CNT_W  (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .timeout(timeout)
`ifdef LIGHT_TIMER_REMAIN_EN
        ,
        .remain (remain)
`endif
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int   exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   base = 0;
    logic prev_to = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_n - base);
        end
    endtask

    // Monitor: every timeout pulse must match the next expected edge number.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_to = 1'b0;
        end else begin
            if (timeout) begin
                if (prev_to) check("timeout_back_to_back", 1, 0);
                if (exp_q.size() == 0) check("unexpected_timeout_edge", edge_n - base, -1);
                else check("timeout_edge", edge_n - base, exp_q.pop_front() - base);
            end
            prev_to = timeout;
        end
    end

    task automatic run_to(input int k);
        while (edge_n < base + k) @(negedge clk);
    endtask

    task automatic do_reset(input logic m);
        rst_n = 1'b0;
        mode  = m;
        repeat (2) @(negedge clk);
        check("reset_timeout", int'(timeout), 0);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("reset_remain", int'(remain), 5);
`endif
        rst_n = 1'b1;
        base  = edge_n;
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);

        // Long mode from reset: pulses after edges 20, 40, 60.
        do_reset(MODE_LONG);
        exp_q.push_back(base + 20);
        exp_q.push_back(base + 40);
        exp_q.push_back(base + 60);
        for (int k = 1; k <= 62; k++) begin
            run_to(k);
`ifdef LIGHT_TIMER_REMAIN_EN
            check("remain_long", int'(remain), 5 - ((k % 20) / 4));
`endif
        end
        drain("long_missing_pulses");

        // Short mode held from reset: edge 1 is a mode change, pulses at 9, 17, 25.
        do_reset(MODE_SHORT);
        exp_q.push_back(base + 9);
        exp_q.push_back(base + 17);
        exp_q.push_back(base + 25);
        run_to(1);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("remain_short_load", int'(remain), 2);
`endif
        run_to(27);
        drain("short_missing_pulses");

        // Reset mid-phase with cnt=2: aborted phase never pulses, fresh 20-cycle phase.
        do_reset(MODE_LONG);
        run_to(10);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("remain_before_abort", int'(remain), 3);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_timeout", int'(timeout), 0);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("abort_remain", int'(remain), 5);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        base  = edge_n;
        exp_q.push_back(base + 20);
        run_to(22);
        drain("abort_missing_pulses");

        // Mode 0->1 in the cycle a tick is due: reload at edge 4, pulses at 12, 20.
        do_reset(MODE_LONG);
        run_to(3);
        mode = MODE_SHORT;
        exp_q.push_back(base + 12);
        exp_q.push_back(base + 20);
        run_to(4);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("remain_tick_toggle", int'(remain), 2);
`endif
        run_to(22);
        drain("tick_toggle_missing_pulses");

        // Mode change in the cycle a timeout is due: change wins, pulses at 28, 36.
        do_reset(MODE_LONG);
        run_to(19);
        mode = MODE_SHORT;
        exp_q.push_back(base + 28);
        exp_q.push_back(base + 36);
        run_to(38);
        drain("timeout_toggle_missing_pulses");

        // FSM-style reaction one cycle after each pulse, then an ignored timeout.
        do_reset(MODE_LONG);
        exp_q.push_back(base + 20);
        run_to(20);
        check("react_pulse_seen", int'(timeout), 1);
        mode = MODE_SHORT;
        exp_q.push_back(base + 29);
        run_to(29);
        mode = MODE_LONG;
        exp_q.push_back(base + 50);
        exp_q.push_back(base + 70);
        run_to(30);
        check("react_no_double", int'(timeout), 0);
`ifdef LIGHT_TIMER_REMAIN_EN
        check("remain_react_reload", int'(remain), 5);
`endif
        run_to(72);
        drain("react_missing_pulses");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
